// File: rtl/hazard_pkg.sv
// Shared types and latency helpers for the scoreboard hazard detector.
package hazard_pkg;

    typedef enum logic [1:0] {
        UNIT_ALU  = 2'd0,
        UNIT_LOAD = 2'd1,
        UNIT_MUL  = 2'd2,
        UNIT_RSVD = 2'd3
    } unit_e;

    localparam int ALU_LAT      = 1;
    localparam int LOAD_LAT_DEF = 2;
    localparam int MUL_LAT_DEF  = 4;

    // Reserved unit code behaves like the ALU.
    function automatic int unit_lat(unit_e unit, int load_lat, int mul_lat);
        case (unit)
            UNIT_LOAD: unit_lat = load_lat;
            UNIT_MUL:  unit_lat = mul_lat;
            default:   unit_lat = ALU_LAT;
        endcase
    endfunction

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        max3 = (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_wb_slot_ring.sv
// Write-back slot reservation ring: bit k means a result writes back k cycles from now.
module wb_slot_ring
    import hazard_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reserve_en,
    input  logic [IDX_W-1:0] reserve_idx,
    input  logic [IDX_W-1:0] query_idx,
    output logic             conflict
);

    logic [DEPTH:0] slots;
    logic [DEPTH:0] slots_next;

    // Advance every reservation one slot closer and add the newly issued one on top.
    always_comb begin
        slots_next = slots >> 1;
        if (reserve_en) begin
            slots_next[reserve_idx] = 1'b1;
        end
    end

    // Reservation register; reset forgets every in-flight write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots <= '0;
        end else begin
            slots <= slots_next;
        end
    end

    assign conflict = slots[query_idx];

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Scoreboard hazard detector in ID: RAW, write-back port and WAW interlocks.
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = LOAD_LAT_DEF,
    parameter int MUL_LAT    = MUL_LAT_DEF,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic                  id_flush,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic [1:0]            id_unit,
    output logic                  PCWrite,
    output logic                  IDWrite,
    output logic                  Stall,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int NREGS  = 2 ** REG_ADDR_W;
    localparam int MAXL   = max3(ALU_LAT, LOAD_LAT, MUL_LAT);
    localparam int BUSY_W = $clog2(MAXL) + 1;
    localparam int IDX_W  = $clog2(MAXL + 1);

    logic [BUSY_W-1:0] busy_cnt [NREGS];

    int                lat;
    logic [BUSY_W-1:0] lat_m1;
    logic [IDX_W-1:0]  lat_idx;
    logic [IDX_W-1:0]  resv_idx;
    logic              live;
    logic              wr;
    logic              raw_hz;
    logic              struct_hz;
    logic              waw_hz;
    logic              hz;
    logic              issue;

    // Latency of the unit the ID instruction will use, in the widths each consumer needs.
    always_comb begin
        lat      = unit_lat(unit_e'(id_unit), LOAD_LAT, MUL_LAT);
        lat_m1   = BUSY_W'(lat - 1);
        lat_idx  = IDX_W'(lat);
        resv_idx = IDX_W'(lat - 1);
    end

    // Hazard decision; a flushed instruction never stalls and never updates state.
    always_comb begin
        live   = id_valid & ~id_flush;
        wr     = live & id_reg_write & (id_rd != '0);
        raw_hz = live & ((id_rs1_used & (id_rs1 != '0) & (busy_cnt[id_rs1] != '0)) |
                         (id_rs2_used & (id_rs2 != '0) & (busy_cnt[id_rs2] != '0)));
        waw_hz = wr & (busy_cnt[id_rd] > lat_m1);
        hz     = raw_hz | (wr & struct_hz) | waw_hz;
        issue  = live & ~hz;
    end

    assign Stall   = hz;
    assign PCWrite = ~hz;
    assign IDWrite = ~hz;

    wb_slot_ring #(
        .DEPTH (MAXL),
        .IDX_W (IDX_W)
    ) u_ring (
        .clk         (clk),
        .rst         (rst),
        .reserve_en  (issue & wr),
        .reserve_idx (resv_idx),
        .query_idx   (lat_idx),
        .conflict    (struct_hz)
    );

    // Per-register countdowns; a fresh issue overrides the decrement of its rd.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                busy_cnt[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (busy_cnt[r] != '0) begin
                    busy_cnt[r] <= busy_cnt[r] - 1'b1;
                end
            end
            if (issue && wr) begin
                busy_cnt[id_rd] <= lat_m1;
            end
        end
    end

    // Saturating count of cycles spent stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (hz && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule
